// File: rtl/anti_theft_second_timer.sv
// anti_theft_second_timer
//   Programmable seconds countdown for the anti-theft FSM. Four interval slots
//   (arm, driver door, passenger door, alarm-on) are held in a small table.
//   start_timer loads the selected slot into a down-counter. The counter is
//   decremented on each one_hz_enable pulse, and expired pulses for one clk
//   when the count reaches zero.
//   Optional feature macro: TIMER_REMAIN_EN adds the remaining_sec output.
module anti_theft_second_timer #(
  parameter int VALUE_W       = 4,
  parameter int DEF_ARM       = 6,
  parameter int DEF_DRIVER    = 8,
  parameter int DEF_PASSENGER = 15,
  parameter int DEF_ALARM     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               one_hz_enable,
  input  logic               start_timer,
  input  logic [1:0]         interval,
  input  logic               reprogram,
  input  logic [1:0]         time_param_sel,
  input  logic [VALUE_W-1:0] time_value,
  output logic               busy,
  output logic               expired
`ifdef TIMER_REMAIN_EN
  ,
  output logic [VALUE_W-1:0] remaining_sec
`endif
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  localparam logic [VALUE_W-1:0] ONE  = VALUE_W'(1);
  localparam logic [VALUE_W-1:0] ZERO = '0;

  localparam logic [VALUE_W-1:0] DEF0 = VALUE_W'(DEF_ARM);
  localparam logic [VALUE_W-1:0] DEF1 = VALUE_W'(DEF_DRIVER);
  localparam logic [VALUE_W-1:0] DEF2 = VALUE_W'(DEF_PASSENGER);
  localparam logic [VALUE_W-1:0] DEF3 = VALUE_W'(DEF_ALARM);

  // A stored interval of zero would make the counter wrap, so it is raised to 1.
  function automatic logic [VALUE_W-1:0] clamp_nonzero(input logic [VALUE_W-1:0] v);
    return (v == ZERO) ? ONE : v;
  endfunction

  logic [0:0]         state_q, state_d;
  logic [VALUE_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               expired_q, expired_d;
  logic [VALUE_W-1:0] table_q [4];
  logic [VALUE_W-1:0] table_d [4];

  // Next-state logic: table write, start/retrigger (wins over a tick), countdown.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    busy_d    = busy_q;
    expired_d = 1'b0;
    table_d   = table_q;

    if (reprogram) begin
      table_d[time_param_sel] = clamp_nonzero(time_value);
    end

    // Start reads table_q, so a same-cycle write to the same slot is seen
    // only by the next start.
    if (start_timer) begin
      count_d = table_q[interval];
      state_d = ST_COUNTING;
      busy_d  = 1'b1;
    end else if (one_hz_enable && (state_q == ST_COUNTING)) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else begin
        count_d   = ZERO;
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        expired_d = 1'b1;
      end
    end
  end

  // State, counter, outputs and interval table, with async reset to defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= ZERO;
      busy_q     <= 1'b0;
      expired_q  <= 1'b0;
      table_q[0] <= DEF0;
      table_q[1] <= DEF1;
      table_q[2] <= DEF2;
      table_q[3] <= DEF3;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      expired_q  <= expired_d;
      table_q    <= table_d;
    end
  end

  assign busy    = busy_q;
  assign expired = expired_q;

`ifdef TIMER_REMAIN_EN
  assign remaining_sec = count_q;
`endif

endmodule
